// File: rtl/vape_exec_proof_reader.sv
`default_nettype none
// ============================================================================
//  Module   : vape_exec_proof_reader
//  Purpose  : Samples the VAPE execution-abort flag, freezes it while the
//             attestation routine runs and exposes it read-only at FLAG_ADDR.
//             Writes to the flag word (CPU or DMA) and illegal entry/exit of
//             the attestation region force a sticky violation that is only
//             cleared when the CPU reaches its reset handler.
//  Ports    : clk, reset_n     - clock (rising edge), async active-low reset
//             pc               - CPU program counter
//             exec_abort       - 1 = executable region not valid
//             data_addr/en/wr  - CPU data bus access
//             dma_addr/en      - DMA access (any DMA hit on FLAG_ADDR = write)
//             exec_ok          - proof value, 1 = execution valid
//             att_active       - attestation in progress
//             violation        - tamper / illegal control flow detected
//             rd_data          - registered readback of the flag word
//  Revision : 1.0 - initial release
// ============================================================================
module vape_exec_proof_reader #(
    parameter logic [15:0] RESET_HANDLER = 16'h0000,
    parameter logic [15:0] ATTEST_MIN    = 16'hA000,
    parameter logic [15:0] ATTEST_MAX    = 16'hDFFE,
    parameter logic [15:0] ATTEST_ENTRY  = 16'hA000,
    parameter logic [15:0] ATTEST_EXIT   = 16'hDFFE,
    parameter logic [15:0] FLAG_ADDR     = 16'h0190
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] pc,
    input  logic        exec_abort,
    input  logic [15:0] data_addr,
    input  logic        data_en,
    input  logic        data_wr,
    input  logic [15:0] dma_addr,
    input  logic        dma_en,
    output logic        exec_ok,
    output logic        att_active,
    output logic        violation,
    output logic [15:0] rd_data
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ATTEST    = 2'd1,
        ST_VIOLATION = 2'd2
    } state_t;

    localparam logic [12:0] c_RD_PAD = 13'd0;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_prev_pc;
    logic        r_exec_ok;
    logic        r_att_active;
    logic        r_violation;
    logic [15:0] r_rd_data;

    logic        w_in_att;
    logic        w_flag_wr;
    logic        w_flag_rd;
    logic        w_bad_exit;
    logic        w_bad_entry;
    logic        w_exec_ok_next;

    assign w_in_att  = (pc >= ATTEST_MIN) && (pc <= ATTEST_MAX);

    // A DMA access cannot be told apart from a write, so any DMA hit counts.
    assign w_flag_wr = (data_en && data_wr && (data_addr == FLAG_ADDR)) ||
                       (dma_en && (dma_addr == FLAG_ADDR));
    assign w_flag_rd = data_en && !data_wr && (data_addr == FLAG_ADDR);

    // Leaving the region is legal only if the previous instruction was the
    // exit address, i.e. control flowed out through ATTEST_EXIT.
    assign w_bad_exit  = (r_state == ST_ATTEST) && !w_in_att &&
                         (r_prev_pc != ATTEST_EXIT);
    assign w_bad_entry = (r_state == ST_IDLE) && w_in_att &&
                         (pc != ATTEST_ENTRY);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_VIOLATION;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and next proof value
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state   = r_state;
        w_exec_ok_next = 1'b0;

        if (w_flag_wr) begin
            w_next_state = ST_VIOLATION;
        end else if (w_bad_exit || w_bad_entry) begin
            w_next_state = ST_VIOLATION;
        end else if ((r_state == ST_ATTEST) && !w_in_att) begin
            w_next_state = ST_IDLE;
        end else if ((r_state == ST_IDLE) && (pc == ATTEST_ENTRY)) begin
            w_next_state = ST_ATTEST;
        end else if ((r_state == ST_VIOLATION) && (pc == RESET_HANDLER)) begin
            w_next_state = ST_IDLE;
        end

        // IDLE tracks the flag (this also covers the capture on the entry
        // edge); ATTEST may only lower the proof; leaving VIOLATION keeps 0
        // for one cycle before IDLE tracking resumes.
        case (r_state)
            ST_IDLE:   w_exec_ok_next = !exec_abort;
            ST_ATTEST: w_exec_ok_next = r_exec_ok && !exec_abort;
            default:   w_exec_ok_next = 1'b0;
        endcase
        if (w_next_state == ST_VIOLATION) begin
            w_exec_ok_next = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs and PC history
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_pc    <= 16'h0000;
            r_exec_ok    <= 1'b0;
            r_att_active <= 1'b0;
            r_violation  <= 1'b1;
            r_rd_data    <= 16'h0000;
        end else begin
            r_prev_pc    <= pc;
            r_exec_ok    <= w_exec_ok_next;
            r_att_active <= (w_next_state == ST_ATTEST);
            r_violation  <= (w_next_state == ST_VIOLATION);
            // Readback reports the register values as they stood before
            // this edge.
            if (w_flag_rd) begin
                r_rd_data <= {c_RD_PAD, r_violation, r_att_active, r_exec_ok};
            end else begin
                r_rd_data <= 16'h0000;
            end
        end
    end

    assign exec_ok    = r_exec_ok;
    assign att_active = r_att_active;
    assign violation  = r_violation;
    assign rd_data    = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_vape_exec_proof_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vape_exec_proof_reader
//  Purpose  : Directed self-checking bench for vape_exec_proof_reader.
//             Expected outputs are queued when a step is driven and popped
//             and compared after the clock edge that produces them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vape_exec_proof_reader;

    localparam logic [1:0] c_NONE = 2'd0;
    localparam logic [1:0] c_RD   = 2'd1;
    localparam logic [1:0] c_WR   = 2'd2;

    logic        clk;
    logic        reset_n;
    logic [15:0] pc;
    logic        exec_abort;
    logic [15:0] data_addr;
    logic        data_en;
    logic        data_wr;
    logic [15:0] dma_addr;
    logic        dma_en;
    logic        exec_ok;
    logic        att_active;
    logic        violation;
    logic [15:0] rd_data;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        v;
        logic        a;
        logic        ok;
        logic [15:0] rd;
    } exp_t;

    exp_t sb_q[$];

    vape_exec_proof_reader dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pc         (pc),
        .exec_abort (exec_abort),
        .data_addr  (data_addr),
        .data_en    (data_en),
        .data_wr    (data_wr),
        .dma_addr   (dma_addr),
        .dma_en     (dma_en),
        .exec_ok    (exec_ok),
        .att_active (att_active),
        .violation  (violation),
        .rd_data    (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check({tag, ".violation"},  {15'd0, violation},  {15'd0, e.v});
        check({tag, ".att_active"}, {15'd0, att_active}, {15'd0, e.a});
        check({tag, ".exec_ok"},    {15'd0, exec_ok},    {15'd0, e.ok});
        check({tag, ".rd_data"},    rd_data,             e.rd);
    endtask

    // One clock step: drive at the falling edge, queue the expected result,
    // then pop and compare 1 time unit after the rising edge.
    task automatic step(input string tag, input logic [15:0] p,
                        input logic ab, input logic [1:0] cpu,
                        input logic dma, input logic [15:0] addr,
                        input logic ev, input logic ea, input logic eok,
                        input logic [15:0] erd);
        exp_t e;
        @(negedge clk);
        pc         = p;
        exec_abort = ab;
        data_en    = (cpu != c_NONE);
        data_wr    = (cpu == c_WR);
        data_addr  = addr;
        dma_en     = dma;
        dma_addr   = addr;
        sb_q.push_back('{v: ev, a: ea, ok: eok, rd: erd});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            check_all(tag, e);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        pc         = 16'h1234;
        exec_abort = 1'b0;
        data_addr  = 16'h0000;
        data_en    = 1'b0;
        data_wr    = 1'b0;
        dma_addr   = 16'h0000;
        dma_en     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_all("reset", '{v: 1'b1, a: 1'b0, ok: 1'b0, rd: 16'h0000});
        @(negedge clk);
        reset_n = 1'b1;

        // Boot: VIOLATION until the reset handler is reached
        step("boot_hold", 16'h1234, 0, c_NONE, 0, 16'h0000, 1, 0, 0, 16'h0000);
        step("boot_rh",   16'h0000, 0, c_NONE, 0, 16'h0000, 0, 0, 0, 16'h0000);
        step("idle_trk1", 16'h0002, 0, c_NONE, 0, 16'h0000, 0, 0, 1, 16'h0000);
        step("idle_trk2", 16'h0004, 1, c_NONE, 0, 16'h0000, 0, 0, 0, 16'h0000);
        step("idle_trk3", 16'h0006, 0, c_NONE, 0, 16'h0000, 0, 0, 1, 16'h0000);

        // Clean attestation with a readback in the middle
        step("att_entry", 16'hA000, 0, c_NONE, 0, 16'h0000, 0, 1, 1, 16'h0000);
        step("att_run",   16'hA002, 0, c_NONE, 0, 16'h0000, 0, 1, 1, 16'h0000);
        step("att_read",  16'hA004, 0, c_RD,   0, 16'h0190, 0, 1, 1, 16'h0003);
        step("att_rd_clr",16'hDFFE, 0, c_NONE, 0, 16'h0000, 0, 1, 1, 16'h0000);
        step("att_exit",  16'hE000, 0, c_NONE, 0, 16'h0000, 0, 0, 1, 16'h0000);
        step("post_exit", 16'hE002, 0, c_NONE, 0, 16'h0000, 0, 0, 1, 16'h0000);

        // Abort pulse during attestation is latched until exit
        step("ab_entry",  16'hA000, 0, c_NONE, 0, 16'h0000, 0, 1, 1, 16'h0000);
        step("ab_pulse",  16'hA002, 1, c_NONE, 0, 16'h0000, 0, 1, 0, 16'h0000);
        step("ab_frozen", 16'hA004, 0, c_NONE, 0, 16'h0000, 0, 1, 0, 16'h0000);
        step("ab_read",   16'hDFFE, 0, c_RD,   0, 16'h0190, 0, 1, 0, 16'h0002);
        step("ab_exit",   16'hE000, 0, c_NONE, 0, 16'h0000, 0, 0, 0, 16'h0000);
        step("ab_retrack",16'hE002, 0, c_NONE, 0, 16'h0000, 0, 0, 1, 16'h0000);

        // Entry with abort asserted is legal; proof frozen at 0
        step("ea_entry",  16'hA000, 1, c_NONE, 0, 16'h0000, 0, 1, 0, 16'h0000);
        step("ea_run",    16'hA002, 0, c_NONE, 0, 16'h0000, 0, 1, 0, 16'h0000);

        // CPU write to flag word in ATTEST
        step("cpu_tamper",16'hA004, 0, c_WR,   0, 16'h0190, 1, 0, 0, 16'h0000);
        step("viol_read", 16'hA006, 0, c_RD,   0, 16'h0190, 1, 0, 0, 16'h0004);
        step("viol_clear",16'h0000, 0, c_NONE, 0, 16'h0000, 0, 0, 0, 16'h0000);
        step("viol_trk",  16'h0002, 0, c_NONE, 0, 16'h0000, 0, 0, 1, 16'h0000);

        // DMA hit coinciding with a legal exit, then with the reset handler
        step("dma_entry", 16'hA000, 0, c_NONE, 0, 16'h0000, 0, 1, 1, 16'h0000);
        step("dma_atexit",16'hDFFE, 0, c_NONE, 0, 16'h0000, 0, 1, 1, 16'h0000);
        step("dma_exit",  16'hE000, 0, c_NONE, 1, 16'h0190, 1, 0, 0, 16'h0000);
        step("dma_rh",    16'h0000, 0, c_NONE, 1, 16'h0190, 1, 0, 0, 16'h0000);
        step("dma_clear", 16'h0000, 0, c_NONE, 0, 16'h0000, 0, 0, 0, 16'h0000);
        step("dma_trk",   16'h0002, 0, c_NONE, 0, 16'h0000, 0, 0, 1, 16'h0000);

        // Illegal entry into the middle of the region
        step("bad_entry", 16'hA010, 0, c_NONE, 0, 16'h0000, 1, 0, 0, 16'h0000);
        step("be_clear",  16'h0000, 0, c_NONE, 0, 16'h0000, 0, 0, 0, 16'h0000);
        step("be_trk",    16'h0002, 0, c_NONE, 0, 16'h0000, 0, 0, 1, 16'h0000);

        // Illegal exit from inside the region
        step("bx_entry",  16'hA000, 0, c_NONE, 0, 16'h0000, 0, 1, 1, 16'h0000);
        step("bx_run",    16'hA100, 0, c_NONE, 0, 16'h0000, 0, 1, 1, 16'h0000);
        step("bad_exit",  16'h4000, 0, c_NONE, 0, 16'h0000, 1, 0, 0, 16'h0000);
        step("bx_clear",  16'h0000, 0, c_NONE, 0, 16'h0000, 0, 0, 0, 16'h0000);
        step("bx_trk",    16'h0002, 0, c_NONE, 0, 16'h0000, 0, 0, 1, 16'h0000);

        // Near-miss addresses and a PC just below the region are harmless
        step("near_addr", 16'h0004, 0, c_WR,   1, 16'h0192, 0, 0, 1, 16'h0000);
        step("near_rd",   16'h0006, 0, c_RD,   0, 16'h018E, 0, 0, 1, 16'h0000);
        step("below_reg", 16'h9FFE, 0, c_NONE, 0, 16'h0000, 0, 0, 1, 16'h0000);
        step("above_reg", 16'hDFFF, 0, c_NONE, 0, 16'h0000, 0, 0, 1, 16'h0000);

        // Reset asserted mid-attestation
        step("mr_entry",  16'hA000, 0, c_NONE, 0, 16'h0000, 0, 1, 1, 16'h0000);
        step("mr_run",    16'hA002, 0, c_NONE, 0, 16'h0000, 0, 1, 1, 16'h0000);
        #2;
        reset_n = 1'b0;
        #1;
        check_all("mid_reset", '{v: 1'b1, a: 1'b0, ok: 1'b0, rd: 16'h0000});
        @(negedge clk);
        reset_n = 1'b1;
        step("mr_hold",   16'hA004, 0, c_NONE, 0, 16'h0000, 1, 0, 0, 16'h0000);
        step("mr_clear",  16'h0000, 0, c_NONE, 0, 16'h0000, 0, 0, 0, 16'h0000);
        step("mr_trk",    16'h0002, 0, c_NONE, 0, 16'h0000, 0, 0, 1, 16'h0000);

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain: observed %0d expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vape_exec_proof_reader.md
# vape_exec_proof_reader

Attestation-side consumer of the VAPE execution flag. The flag monitor produces an abort indication (`exec_abort`, 1 = executable region modified or not yet validated). This block samples that indication, freezes it for the duration of the attestation routine, and exposes it read-only to software at a fixed data address. Any tampering attempt, whether a CPU or DMA write to the flag address or leaving the attestation region other than through its exit address, forces a violation that only a CPU reset clears.

## Interface
Parameters:
- `RESET_HANDLER`, 16'h0000: PC value that marks completion of the reset sequence.
- `ATTEST_MIN`, 16'hA000: lowest address of the attestation code region.
- `ATTEST_MAX`, 16'hDFFE: highest address of the attestation code region.
- `ATTEST_ENTRY`, 16'hA000: the only legal entry PC.
- `ATTEST_EXIT`, 16'hDFFE: the only PC from which the region may be left legally.
- `FLAG_ADDR`, 16'h0190: address of the flag readback word.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `pc` in 16: current CPU program counter.
- `exec_abort` in 1: flag from the VAPE execution monitor; 1 = execution not valid.
- `data_addr` in 16: CPU data bus address.
- `data_en` in 1: CPU data access valid.
- `data_wr` in 1: CPU access is a write (qualified by `data_en`).
- `dma_addr` in 16: DMA address.
- `dma_en` in 1: DMA access valid (treated as a write for protection purposes).
- `exec_ok` out 1: frozen or tracking proof value; 1 = execution valid.
- `att_active` out 1: attestation in progress.
- `violation` out 1: tamper or illegal-exit condition; held until reset completes.
- `rd_data` out 16: registered readback data.

## Operation
- State register: IDLE, ATTEST, VIOLATION. `prev_pc` is a 16-bit register holding the last cycle's `pc`.
- `in_att` = `pc` >= `ATTEST_MIN` && `pc` <= `ATTEST_MAX`. Compares are unsigned and inclusive.
- `flag_wr` = (`data_en` && `data_wr` && `data_addr` == `FLAG_ADDR`) || (`dma_en` && `dma_addr` == `FLAG_ADDR`).
- `bad_exit` = state ATTEST && !`in_att` && `prev_pc` != `ATTEST_EXIT`.
- `bad_entry` = state IDLE && `in_att` && `pc` != `ATTEST_ENTRY`.
- Transition priority, highest first:
  1. `flag_wr` from any state goes to VIOLATION.
  2. `bad_exit` or `bad_entry` goes to VIOLATION.
  3. ATTEST && !`in_att` (legal exit) goes to IDLE.
  4. IDLE && `pc` == `ATTEST_ENTRY` goes to ATTEST.
  5. VIOLATION && `pc` == `RESET_HANDLER` goes to IDLE.
  6. Otherwise the state holds.
- `exec_ok` update:
  - IDLE: `exec_ok` <= !`exec_abort` (tracks the flag).
  - Entry edge (IDLE to ATTEST): captures !`exec_abort`.
  - ATTEST: `exec_ok` <= `exec_ok` && !`exec_abort`. It can fall but never rise, so an abort during attestation is recorded.
  - VIOLATION, or any edge entering VIOLATION: `exec_ok` <= 0.
  - Leaving VIOLATION: IDLE resumes tracking on the next cycle.
- `att_active` = (state == ATTEST), registered. `violation` = (state == VIOLATION), registered.
- Readback: if `data_en` && !`data_wr` && `data_addr` == `FLAG_ADDR`, then `rd_data` <= {13'b0, `violation`, `att_active`, `exec_ok`}. The sampled values are the pre-edge register values. Otherwise `rd_data` <= 16'h0000.
- A DMA read of `FLAG_ADDR` is indistinguishable from a write and causes VIOLATION.

## Timing
- `reset_n` low, asynchronously:
  - state = VIOLATION, `violation` = 1, `exec_ok` = 0, `att_active` = 0, `rd_data` = 0, `prev_pc` = 0.
  - After deassertion, IDLE is reached on the first edge with `pc` == `RESET_HANDLER`.
- Reset asserted mid-attestation: the same values apply immediately; the frozen proof is lost.
- All outputs are registered and change only on the `clk` rising edge, one cycle after the causing input. Readback latency is 1 cycle.
- Simultaneous events resolve by the priority list:
  - `flag_wr` and legal exit in the same cycle: VIOLATION.
  - `flag_wr` and `pc` == `RESET_HANDLER` while in VIOLATION: stays in VIOLATION.
- Entering at `ATTEST_ENTRY` with `exec_abort` = 1 is legal. `exec_ok` = 0 is frozen, no violation.
- A legal exit requires `prev_pc` == `ATTEST_EXIT` on the cycle `pc` first leaves the region. Because of this, `ATTEST_EXIT` itself must be inside the region.

## Test plan
- Reset then boot: hold `reset_n` = 0, release, drive `pc` = 16'h0000. Required: `violation` = 1 until the edge; then `violation` = 0, and `exec_ok` follows !`exec_abort` one cycle later.
- Clean attestation: `exec_abort` = 0, `pc` steps 16'hA000, then in-region values, then 16'hDFFE, then 16'hE000. Required: `att_active` = 1 from the cycle after 16'hA000, `exec_ok` = 1 throughout, return to IDLE after 16'hE000, `violation` stays 0.
- Abort during attestation: in ATTEST, pulse `exec_abort` for 1 cycle. Required: `exec_ok` = 0 next cycle and stays 0 through the rest of ATTEST.
- Tamper: in ATTEST, issue a CPU write to 16'h0190 (or `dma_en` with `dma_addr` = 16'h0190). Required: next cycle `violation` = 1, `exec_ok` = 0, `att_active` = 0. Cleared only after `pc` = 16'h0000.
- Illegal control flow: jump to `pc` = 16'hA010 from IDLE, or leave ATTEST from 16'hA100 to 16'h4000. Required: VIOLATION next cycle in both cases.
- Readback: CPU read of 16'h0190 in ATTEST with `exec_ok` = 1. Required: `rd_data` = 16'h0003 one cycle later, and 16'h0000 the cycle after if no new read.
